// File: rtl/vid_console_sched.sv
// vid_console_sched: schedules CPU and teletype writes onto the video port.
// Optional drawn cursor: define VIDCON_CURSOR_EN.
module vid_console_sched #(
    parameter int          COLS        = 100,
    parameter int          ROWS        = 50,
    parameter int          SYM_BASE    = 1024,
    parameter logic [15:0] BLANK_CODE  = 16'h0020
`ifdef VIDCON_CURSOR_EN
    ,
    parameter logic [15:0] CURSOR_CODE = 16'h005F
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic [12:0] cpu_addr,
    input  logic [31:0] cpu_value,
    output logic        cpu_ack,
    input  logic        tty_valid,
    input  logic [7:0]  tty_char,
    output logic        tty_ready,
    input  logic        clr_start,
    output logic        busy,
    output logic [6:0]  cur_col,
    output logic [5:0]  cur_row,
    output logic        vid_write,
    output logic [12:0] vid_addr,
    output logic [31:0] vid_value
);

    typedef enum logic [2:0] {
        IDLE, PUT, BS_WR, CLR_ROW, CLR_ALL
`ifdef VIDCON_CURSOR_EN
        , ERASE_CUR, DRAW_CUR
`endif
    } state_t;

`ifdef VIDCON_CURSOR_EN
    localparam state_t DONE = DRAW_CUR;
    typedef enum logic [1:0] {OP_CR, OP_LF, OP_BS} op_t;
    op_t op, op_d;
`else
    localparam state_t DONE = IDLE;
`endif

    state_t      state, state_d;
    logic [6:0]  col, col_d;
    logic [5:0]  row, row_d, row_nx;
    logic [12:0] base, base_d, base_nx;
    logic [12:0] cnt, cnt_d;
    logic [7:0]  chr, chr_d;
    logic        eng_req, eng_go, use_cnt;
    logic        cpu_grant, last_row;
    logic [15:0] eng_sym;
    logic [12:0] eng_addr;

    assign cpu_grant = cpu_req && !cpu_ack;
    assign eng_go    = eng_req && !cpu_grant;
    assign last_row  = (row == 6'(ROWS - 1));
    assign row_nx    = last_row ? '0 : row + 6'd1;
    assign base_nx   = last_row ? '0 : base + 13'(COLS);
    assign eng_addr  = 13'(SYM_BASE) + base + (use_cnt ? cnt : {6'd0, col});
    assign busy      = (state != IDLE);
    assign tty_ready = reset_n && (state == IDLE) && !clr_start;
    assign cur_col   = col;
    assign cur_row   = row;

    // Engine next-state, cursor update and write request.
    always_comb begin
        state_d = state;
        col_d   = col;
        row_d   = row;
        base_d  = base;
        cnt_d   = cnt;
        chr_d   = chr;
        eng_req = 1'b0;
        eng_sym = BLANK_CODE;
        use_cnt = 1'b0;
`ifdef VIDCON_CURSOR_EN
        op_d    = op;
`endif
        case (state)
            IDLE: begin
                if (clr_start || (tty_valid && tty_char == 8'h0C)) begin
                    state_d = CLR_ALL;
                    col_d   = '0;
                    row_d   = '0;
                    base_d  = '0;
                    cnt_d   = '0;
                end else if (tty_valid) begin
                    chr_d = tty_char;
                    case (tty_char)
`ifdef VIDCON_CURSOR_EN
                        8'h0D: begin
                            state_d = ERASE_CUR;
                            op_d    = OP_CR;
                        end
                        8'h0A: begin
                            state_d = ERASE_CUR;
                            op_d    = OP_LF;
                        end
                        8'h08: begin
                            if (col != '0) begin
                                state_d = ERASE_CUR;
                                op_d    = OP_BS;
                            end
                        end
`else
                        8'h0D: col_d = '0;
                        8'h0A: begin
                            col_d   = '0;
                            row_d   = row_nx;
                            base_d  = base_nx;
                            cnt_d   = '0;
                            state_d = CLR_ROW;
                        end
                        8'h08: begin
                            if (col != '0) begin
                                col_d   = col - 7'd1;
                                state_d = BS_WR;
                            end
                        end
`endif
                        default: state_d = PUT;
                    endcase
                end
            end
            PUT: begin
                eng_req = 1'b1;
                eng_sym = {8'd0, chr};
                if (eng_go) begin
                    if (col < 7'(COLS - 1)) begin
                        col_d   = col + 7'd1;
                        state_d = DONE;
                    end else begin
                        col_d   = '0;
                        row_d   = row_nx;
                        base_d  = base_nx;
                        cnt_d   = '0;
                        state_d = CLR_ROW;
                    end
                end
            end
            BS_WR: begin
                eng_req = 1'b1;
                if (eng_go) state_d = DONE;
            end
            CLR_ROW: begin
                eng_req = 1'b1;
                use_cnt = 1'b1;
                if (eng_go) begin
                    if (cnt == 13'(COLS - 1)) state_d = DONE;
                    else cnt_d = cnt + 13'd1;
                end
            end
            CLR_ALL: begin
                eng_req = 1'b1;
                use_cnt = 1'b1;
                if (eng_go) begin
                    if (cnt == 13'(ROWS * COLS - 1)) state_d = DONE;
                    else cnt_d = cnt + 13'd1;
                end
            end
`ifdef VIDCON_CURSOR_EN
            ERASE_CUR: begin
                eng_req = 1'b1;
                if (eng_go) begin
                    case (op)
                        OP_LF: begin
                            col_d   = '0;
                            row_d   = row_nx;
                            base_d  = base_nx;
                            cnt_d   = '0;
                            state_d = CLR_ROW;
                        end
                        OP_BS: begin
                            col_d   = col - 7'd1;
                            state_d = BS_WR;
                        end
                        default: begin
                            col_d   = '0;
                            state_d = DRAW_CUR;
                        end
                    endcase
                end
            end
            DRAW_CUR: begin
                eng_req = 1'b1;
                eng_sym = CURSOR_CODE;
                if (eng_go) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Engine state, cursor position and clear counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
            base  <= '0;
            cnt   <= '0;
            chr   <= '0;
`ifdef VIDCON_CURSOR_EN
            op    <= OP_CR;
`endif
        end else begin
            state <= state_d;
            col   <= col_d;
            row   <= row_d;
            base  <= base_d;
            cnt   <= cnt_d;
            chr   <= chr_d;
`ifdef VIDCON_CURSOR_EN
            op    <= op_d;
`endif
        end
    end

    // Registered video write port; the CPU wins any contended cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_ack   <= 1'b0;
            vid_write <= 1'b0;
            vid_addr  <= '0;
            vid_value <= '0;
        end else begin
            cpu_ack   <= cpu_grant;
            vid_write <= cpu_grant || eng_req;
            if (cpu_grant) begin
                vid_addr  <= cpu_addr;
                vid_value <= cpu_value;
            end else if (eng_req) begin
                vid_addr  <= eng_addr;
                vid_value <= {16'd0, eng_sym};
            end
        end
    end

endmodule

// File: tb/tb_vid_console_sched.sv
// tb_vid_console_sched: directed vectors and multi-cycle sequences
// for the video console write scheduler.
module tb_vid_console_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req;
    logic [12:0] cpu_addr;
    logic [31:0] cpu_value;
    logic        cpu_ack;
    logic        tty_valid;
    logic [7:0]  tty_char;
    logic        tty_ready;
    logic        clr_start;
    logic        busy;
    logic [6:0]  cur_col;
    logic [5:0]  cur_row;
    logic        vid_write;
    logic [12:0] vid_addr;
    logic [31:0] vid_value;

    vid_console_sched dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_value (cpu_value),
        .cpu_ack   (cpu_ack),
        .tty_valid (tty_valid),
        .tty_char  (tty_char),
        .tty_ready (tty_ready),
        .clr_start (clr_start),
        .busy      (busy),
        .cur_col   (cur_col),
        .cur_row   (cur_row),
        .vid_write (vid_write),
        .vid_addr  (vid_addr),
        .vid_value (vid_value)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [12:0] a;
        logic [31:0] v;
        logic        k;
    } wr_t;

    wr_t wq[$];

    // Record every video write seen on the port.
    always @(negedge clk) begin
        if (vid_write) wq.push_back({vid_addr, vid_value, cpu_ack});
    end

    typedef struct {
        logic [7:0]  c;
        int          nw;
        int          bc;
        logic [12:0] a0;
        logic [31:0] v0;
        logic [12:0] al;
        logic [6:0]  col;
        logic [5:0]  row;
    } vec_t;

    vec_t vt[9];
    int   n_run  = 0;
    int   n_fail = 0;
    int   cyc;
    int   bad;
    int   n;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        int k;
        k = 0;
        tty_valid = 1'b1;
        tty_char  = c;
        #1;
        while (!tty_ready && k < 20000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("send_accept", tty_ready, 1);
        @(negedge clk);
        tty_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max, output int c);
        c = 0;
        while (busy && c < max) begin
            @(negedge clk);
            c++;
        end
        chk("idle_timeout", busy, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        cpu_req   = 1'b0;
        cpu_addr  = '0;
        cpu_value = '0;
        tty_valid = 1'b0;
        tty_char  = '0;
        clr_start = 1'b0;

        vt[0] = '{8'h41, 1, 1, 13'd1024, 32'h41, 13'd1024, 7'd1, 6'd0};
        vt[1] = '{8'h42, 1, 1, 13'd1025, 32'h42, 13'd1025, 7'd2, 6'd0};
        vt[2] = '{8'h08, 1, 1, 13'd1025, 32'h20, 13'd1025, 7'd1, 6'd0};
        vt[3] = '{8'h0D, 0, 0, 13'd0, 32'h0, 13'd0, 7'd0, 6'd0};
        vt[4] = '{8'h08, 0, 0, 13'd0, 32'h0, 13'd0, 7'd0, 6'd0};
        vt[5] = '{8'h7A, 1, 1, 13'd1024, 32'h7A, 13'd1024, 7'd1, 6'd0};
        vt[6] = '{8'h0A, 100, 100, 13'd1124, 32'h20, 13'd1223, 7'd0, 6'd1};
        vt[7] = '{8'h43, 1, 1, 13'd1124, 32'h43, 13'd1124, 7'd1, 6'd1};
        vt[8] = '{8'h0C, 5000, 5000, 13'd1024, 32'h20, 13'd6023, 7'd0, 6'd0};

        repeat (3) @(negedge clk);
        chk("rst_vid_write", vid_write, 0);
        chk("rst_vid_addr", vid_addr, 0);
        chk("rst_vid_value", vid_value, 0);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tty_ready", tty_ready, 0);
        chk("rst_cursor", {cur_row, cur_col}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_after", tty_ready, 1);

        for (int i = 0; i < 9; i++) begin
            wq.delete();
            send(vt[i].c);
            wait_idle(6000, cyc);
            chk($sformatf("v%0d_nwr", i), wq.size(), vt[i].nw);
            chk($sformatf("v%0d_busy", i), cyc, vt[i].bc);
            if (vt[i].nw > 0 && wq.size() > 0) begin
                chk($sformatf("v%0d_addr0", i), wq[0].a, vt[i].a0);
                chk($sformatf("v%0d_val0", i), wq[0].v, vt[i].v0);
                chk($sformatf("v%0d_addrl", i), wq[wq.size()-1].a, vt[i].al);
            end
            chk($sformatf("v%0d_col", i), cur_col, vt[i].col);
            chk($sformatf("v%0d_row", i), cur_row, vt[i].row);
        end

        send(8'h41);
        wait_idle(10, cyc);
        wq.delete();
        cpu_req   = 1'b1;
        cpu_addr  = 13'h0005;
        cpu_value = 32'hDEADBEEF;
        tty_valid = 1'b1;
        tty_char  = 8'h42;
        #1;
        chk("c1_ready", tty_ready, 1);
        @(negedge clk);
        tty_valid = 1'b0;
        chk("c1_ack", cpu_ack, 1);
        @(negedge clk);
        cpu_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("c1_nwr", wq.size(), 2);
        if (wq.size() == 2) begin
            chk("c1_cpu_addr", wq[0].a, 13'h0005);
            chk("c1_cpu_val", wq[0].v, 32'hDEADBEEF);
            chk("c1_cpu_ack", wq[0].k, 1);
            chk("c1_tty_addr", wq[1].a, 13'd1025);
            chk("c1_tty_val", wq[1].v, 32'h42);
            chk("c1_tty_ack", wq[1].k, 0);
        end
        chk("c1_col", cur_col, 2);

        wq.delete();
        tty_valid = 1'b1;
        tty_char  = 8'h43;
        @(negedge clk);
        tty_valid = 1'b0;
        cpu_req   = 1'b1;
        cpu_addr  = 13'h0010;
        cpu_value = 32'h12345678;
        @(negedge clk);
        cpu_req = 1'b0;
        chk("c2_stall_busy", busy, 1);
        chk("c2_stall_col", cur_col, 2);
        repeat (4) @(negedge clk);
        chk("c2_nwr", wq.size(), 2);
        if (wq.size() == 2) begin
            chk("c2_cpu_addr", wq[0].a, 13'h0010);
            chk("c2_tty_addr", wq[1].a, 13'd1026);
            chk("c2_tty_val", wq[1].v, 32'h43);
        end
        chk("c2_col", cur_col, 3);

        do_reset();
        wq.delete();
        for (int i = 0; i < 100; i++) send(8'h30 + 8'(i % 10));
        wait_idle(200, cyc);
        chk("wrap_nwr", wq.size(), 200);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (i < wq.size()) begin
                if (i < 100) begin
                    if (wq[i].a != 13'(1024 + i) ||
                        wq[i].v != 32'(8'h30 + i % 10)) bad++;
                end else begin
                    if (wq[i].a != 13'(1124 + i - 100) ||
                        wq[i].v != 32'h20) bad++;
                end
            end
        end
        chk("wrap_bad", bad, 0);
        chk("wrap_col", cur_col, 0);
        chk("wrap_row", cur_row, 1);

        for (int i = 0; i < 48; i++) send(8'h0A);
        wait_idle(200, cyc);
        chk("lf_row49", cur_row, 49);
        wq.delete();
        send(8'h0A);
        wait_idle(200, cyc);
        chk("lfw_row", cur_row, 0);
        chk("lfw_nwr", wq.size(), 100);
        if (wq.size() > 0) begin
            chk("lfw_addr0", wq[0].a, 13'd1024);
            chk("lfw_addrl", wq[wq.size()-1].a, 13'd1123);
        end

        send(8'h78);
        wait_idle(10, cyc);
        wq.delete();
        clr_start = 1'b1;
        tty_valid = 1'b1;
        tty_char  = 8'h51;
        #1;
        chk("clr_ready_low", tty_ready, 0);
        @(negedge clk);
        clr_start = 1'b0;
        tty_valid = 1'b0;
        chk("clr_busy", busy, 1);
        chk("clr_col0", cur_col, 0);
        n = 0;
        while (busy && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("clr_cycles", n, 5000);
        chk("clr_last_wr", vid_write, 1);
        chk("clr_last_addr", vid_addr, 13'd6023);
        repeat (2) @(negedge clk);
        chk("clr_nwr", wq.size(), 5000);
        bad = 0;
        for (int i = 0; i < wq.size(); i++) begin
            if (wq[i].a != 13'(1024 + i) || wq[i].v != 32'h20) bad++;
        end
        chk("clr_bad", bad, 0);
        chk("clr_cursor", {cur_row, cur_col}, 0);

        send(8'h0C);
        repeat (100) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rmid_vid_write", vid_write, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_cursor", {cur_row, cur_col}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        wq.delete();
        send(8'h41);
        wait_idle(10, cyc);
        chk("rmid_nwr", wq.size(), 1);
        if (wq.size() > 0) chk("rmid_addr", wq[0].a, 13'd1024);
        chk("rmid_col", cur_col, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
